serial_operand_deserializer: RTL and testbench
==============================================

// Module: serial_operand_deserializer
// PURPOSE
//   Bit-serial to N-bit parallel receiver for the BasicCombinationalLogic operand path.
//   - Upstream: collects N serial bits through a valid/ready handshake.
//   - Downstream: presents the assembled word through a valid/ready handshake.
//   - Also registers a zero flag (~|word) alongside the word, so the
//     unary/reduction units and their benches can be fed and cross-checked.
// PARAMETERS
//   N          8   Word width in bits; legal range N >= 2.
//   MSB_FIRST  1   1: first serial bit lands in m_data[N-1]; 0: first bit lands in m_data[0].
// PORTS
//   clk      in   1   Clock; all state is updated on the rising edge.
//   rst      in   1   Reset; asynchronous assert, active-high.
//   s_valid  in   1   Serial bit valid.
//   s_data   in   1   Serial bit.
//   s_ready  out  1   Deserializer can accept a bit this cycle.
//   m_valid  out  1   Assembled word valid.
//   m_data   out  N   Assembled word.
//   m_zero   out  1   1 when m_data == 0, i.e. ~|m_data; qualified by m_valid.
//   m_ready  in   1   Downstream accepts the word.
// BEHAVIOUR
//   Interface
//   - One clock. Reset is asynchronous and active-high.
//   Reset values
//   - m_valid=0, m_data=0, m_zero=0, bit count=0, state=FILL.
//   - All take effect immediately when rst asserts, independent of clk.
//   - Reset mid-word or mid-hold discards any partial or held word. No output pulse results.
//   Handshake rules
//   - s_ready = !m_valid || m_ready (combinational). It is 1 after reset.
//   - A bit is accepted on a rising edge where s_valid && s_ready.
//   - A word is consumed on a rising edge where m_valid && m_ready.
//   - m_data and m_zero hold stable while m_valid && !m_ready.
//   - m_valid never deasserts without a consume.
//   State machine
//   - FILL: collecting bits; count runs 0..N-1, width $clog2(N).
//     - Each accepted bit shifts into the shift register and increments count.
//     - On accepting bit N-1: count wraps to 0, the shift result loads m_data,
//       m_zero <= ~|result, m_valid <= 1, state -> FULL.
//     - Latency: m_valid rises on the edge that accepts the Nth bit, visible the
//       following cycle. No extra pipeline stage.
//   - FULL: word held.
//     - With m_ready=0: s_ready=0, no bits accepted.
//     - With m_ready=1 and s_valid=0: m_valid <= 0, state -> FILL, count stays 0.
//     - Simultaneous consume + bit accept (m_ready=1, s_valid=1): the word is
//       consumed and the bit becomes bit 0 of the next word, so count <= 1 and
//       state -> FILL. Throughput is therefore one word per N cycles, with no bubble.
//   Bit order
//   - MSB_FIRST=1: shreg <= {shreg[N-2:0], s_data}.
//   - MSB_FIRST=0: shreg <= {s_data, shreg[N-1:1]}.
//   Other rules
//   - s_data is ignored when s_valid=0.
//   - m_ready is ignored when m_valid=0. There is no partial-word flush.
// TESTING (N=8 unless noted)
//   1. Reset, then send 1,0,1,1,0,0,1,0 back-to-back with MSB_FIRST=1 and m_ready=1
//      -> m_valid high for 1 cycle, the cycle after bit 8; m_data=8'hB2, m_zero=0.
//   2. Same bits with MSB_FIRST=0
//      -> m_data=8'h4D. Then send eight 0 bits -> m_data=8'h00, m_zero=1.
//   3. Hold m_ready=0 after a word 8'hA5 completes, with s_valid held high
//      -> s_ready=0, m_data stays 8'hA5 for 5 cycles, no bits lost; raising m_ready
//      consumes and accepts the next bit the same edge (count=1).
//   4. Continuous stream of 3 words (24 bits, s_valid=1, m_ready=1)
//      -> 3 m_valid pulses exactly 8 cycles apart, data matches, s_ready never drops.
//   5. Assert rst asynchronously after 5 of 8 bits, then send 8 fresh bits 8'h3C
//      -> no stray m_valid; output word is 8'h3C, not contaminated by the old bits.
//   6. Set N=2, send 1,1 then 0,1
//      -> words 2'b11 (m_zero=0) and 2'b01; count wraps correctly at the minimum width.

Source files
------------

// File: rtl/serial_operand_deserializer.sv
// serial_operand_deserializer
//   Bit-serial to N-bit parallel receiver. Serial bits come in through a
//   valid/ready handshake. Once N bits are collected, the assembled word is
//   presented on a valid/ready output. A zero flag is registered with the word.
//
// Parameters
//   N          word width (N >= 2)
//   MSB_FIRST  1: first serial bit lands in m_data[N-1]; 0: it lands in m_data[0]
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous reset, active high
//   s_valid  serial bit valid
//   s_data   serial bit
//   s_ready  a bit can be accepted this cycle (combinational)
//   m_valid  assembled word valid
//   m_data   assembled word
//   m_zero   registered ~|m_data, qualified by m_valid
//   m_ready  downstream accepts the word
module serial_operand_deserializer #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic         s_data,
   output logic         s_ready,
   output logic         m_valid,
   output logic [N-1:0] m_data,
   output logic         m_zero,
   input  logic         m_ready
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {FILL, FULL} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [N-1:0]   shreg;
   logic [N-1:0]   shreg_nxt;
   logic           accept;

   // A held word that is being consumed frees the slot in the same cycle.
   // This lets the stream run without a bubble.
   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;

   if (MSB_FIRST) begin : g_msb
      assign shreg_nxt = {shreg[N-2:0], s_data};
   end else begin : g_lsb
      assign shreg_nxt = {s_data, shreg[N-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FILL;
         count   <= '0;
         shreg   <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_zero  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  shreg <= shreg_nxt;
                  if (count == LAST) begin
                     count   <= '0;
                     m_data  <= shreg_nxt;
                     m_zero  <= ~|shreg_nxt;
                     m_valid <= 1'b1;
                     state   <= FULL;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
            end
            FULL: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= FILL;
                  // A bit accepted on the consume edge is bit 0 of the next
                  // word. Stale bits left in shreg are shifted out before the
                  // next word loads.
                  if (s_valid) begin
                     shreg <= shreg_nxt;
                     count <= CW'(1);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_operand_deserializer.sv
// Bench for serial_operand_deserializer. Three instances share one input
// stream: N=8 MSB-first, N=8 LSB-first, and N=2 MSB-first. Each instance has
// its own reference model. The model places every accepted bit directly at
// its final word position and publishes the word once N bits have arrived.
module tb_serial_operand_deserializer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s_valid = 1'b0, s_data = 1'b0, m_ready = 1'b0;

   logic       rdy [3];
   logic       mv  [3];
   logic       mz  [3];
   logic [7:0] d8m, d8l;
   logic [1:0] d2;
   logic [7:0] dout [3];

   always #5 clk = ~clk;

   serial_operand_deserializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[0]),
      .m_valid(mv[0]), .m_data(d8m), .m_zero(mz[0]), .m_ready(m_ready));
   serial_operand_deserializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[1]),
      .m_valid(mv[1]), .m_data(d8l), .m_zero(mz[1]), .m_ready(m_ready));
   serial_operand_deserializer #(.N(2), .MSB_FIRST(1'b1)) u_n2 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(rdy[2]),
      .m_valid(mv[2]), .m_data(d2), .m_zero(mz[2]), .m_ready(m_ready));

   assign dout[0] = d8m;
   assign dout[1] = d8l;
   assign dout[2] = {6'b0, d2};

   // reference model state
   int   n_of   [3] = '{8, 8, 2};
   bit   msb_of [3] = '{1'b1, 1'b0, 1'b1};
   bit   e_mv   [3];
   bit   e_mz   [3];
   logic [7:0] e_md  [3];
   logic [7:0] e_acc [3];
   int   e_cnt  [3];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         e_mv[i] = 1'b0; e_mz[i] = 1'b0; e_md[i] = '0; e_acc[i] = '0; e_cnt[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit sv, input bit sd, input bit mr);
      bit take;
      int pos;
      take = sv && (!e_mv[i] || mr);
      if (e_mv[i] && mr) e_mv[i] = 1'b0;
      if (take) begin
         if (e_cnt[i] == 0) e_acc[i] = '0;
         pos = msb_of[i] ? n_of[i] - 1 - e_cnt[i] : e_cnt[i];
         e_acc[i][pos] = sd;
         e_cnt[i]++;
         if (e_cnt[i] == n_of[i]) begin
            e_mv[i]  = 1'b1;
            e_md[i]  = e_acc[i];
            e_mz[i]  = (e_acc[i] == 8'h00);
            e_cnt[i] = 0;
         end
      end
   endtask

   task automatic check_outputs(input string ph);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_mvalid_u%0d_c%0d", ph, i, cyc), 32'(mv[i]), 32'(e_mv[i]));
         chk($sformatf("%s_mdata_u%0d_c%0d", ph, i, cyc), 32'(dout[i]), 32'(e_md[i]));
         chk($sformatf("%s_mzero_u%0d_c%0d", ph, i, cyc), 32'(mz[i]), 32'(e_mz[i]));
      end
   endtask

   // One clock: drive, check combinational s_ready, clock, then check registers.
   task automatic cycle(input bit sv, input bit sd, input bit mr);
      s_valid = sv; s_data = sd; m_ready = mr;
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("sready_u%0d_c%0d", i, cyc), 32'(rdy[i]), 32'(!e_mv[i] || mr));
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i, sv, sd, mr);
      #1;
      cyc++;
      check_outputs("out");
   endtask

   // Reset is asserted between edges, so the async path alone must clear outputs.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs("rst");
      for (int i = 0; i < 3; i++) chk($sformatf("rst_sready_u%0d", i), 32'(rdy[i]), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit mr);
      logic [7:0] v;
      v = b;
      for (int k = 7; k >= 0; k--) cycle(1'b1, v[k], mr);
   endtask

   int pulses[$];

   initial begin
      model_reset();
      async_reset();

      // 1/2: 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
      send_byte(8'hB2, 1'b1);
      chk("t1_msb_data", 32'(d8m), 32'hB2);
      chk("t1_msb_valid", 32'(mv[0]), 32'd1);
      chk("t2_lsb_data", 32'(d8l), 32'h4D);
      chk("t1_msb_zero", 32'(mz[0]), 32'd0);
      cycle(1'b0, 1'b0, 1'b1);
      chk("t1_one_cycle_pulse", 32'(mv[0]), 32'd0);
      send_byte(8'h00, 1'b1);
      chk("t2_zero_data", 32'(d8l), 32'h00);
      chk("t2_zero_flag", 32'(mz[1]), 32'd1);
      cycle(1'b0, 1'b0, 1'b1);

      // 3: hold A5 under backpressure with s_valid high
      async_reset();
      send_byte(8'hA5, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 1'b1, 1'b0);
         chk("t3_hold_data", 32'(d8m), 32'hA5);
         chk("t3_hold_sready", 32'(rdy[0]), 32'd0);
      end
      // Consume and accept on the same edge, then finish with seven bits: 1_0011100 = 9C.
      cycle(1'b1, 1'b1, 1'b1);
      chk("t3_consumed", 32'(mv[0]), 32'd0);
      for (int k = 0; k < 7; k++) cycle(1'b1, (k >= 2 && k <= 4), 1'b1);
      chk("t3_next_word", 32'(d8m), 32'h9C);

      // 4: 24 back-to-back bits, three evenly spaced pulses
      async_reset();
      pulses.delete();
      for (int w = 0; w < 3; w++) begin
         logic [7:0] b;
         b = 8'($urandom);
         for (int k = 7; k >= 0; k--) begin
            cycle(1'b1, b[k], 1'b1);
            if (mv[0]) pulses.push_back(cyc);
         end
      end
      chk("t4_pulse_count", pulses.size(), 3);
      if (pulses.size() == 3) begin
         chk("t4_gap1", pulses[1] - pulses[0], 8);
         chk("t4_gap2", pulses[2] - pulses[1], 8);
      end

      // 5: reset after five bits, then a clean 3C
      async_reset();
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b1);
      async_reset();
      send_byte(8'h3C, 1'b1);
      chk("t5_clean_word", 32'(d8m), 32'h3C);

      // 6: N=2 instance gets 1,1 then 0,1
      async_reset();
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      chk("t6_w0", 32'(d2), 32'h3);
      chk("t6_w0_zero", 32'(mz[2]), 32'd0);
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      chk("t6_w1", 32'(d2), 32'h1);
      chk("t6_w1_valid", 32'(mv[2]), 32'd1);

      // random traffic with occasional async reset
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) async_reset();
         cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) < 7);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
